hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Load-use hazard detector for the five-stage pipeline, sitting between the ID and EX stage registers. It flags when the instruction in ID reads a register that the load currently in EX will write, asserting a one-cycle stall that freezes PC and IF/ID and injects a bubble into ID/EX. A small clocked section records the previous stall and counts stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; the single clock of the block, rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- MemRead_EX  input  1  the instruction in EX is a load.
- Rs_ID  input  5  first source register of the instruction in ID.
- Rt_ID  input  5  second source register of the instruction in ID.
- Rt_EX  input  5  destination register of the load in EX.
- Stall  output  1  load-use hazard detected this cycle (combinational).
- PC_Write  output  1  PC update enable; equals ~Stall.
- IF_ID_Write  output  1  IF/ID register write enable; equals ~Stall.
- Bubble_EX  output  1  zero the ID/EX control fields; equals Stall.
- Stall_Prev  output  1  registered copy of Stall from the previous cycle.
- Stall_Count  output  CNT_W  saturating count of cycles with Stall=1.

## Operation
- Hazard condition: Stall = rst_n & MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID)).
- Register 0 never causes a stall, because a load to $zero has no consumer dependency.
- A match on either Rs_ID or Rt_ID is sufficient. A match on both produces a single stall, not two.
- With MemRead_EX=0, Stall=0 regardless of register fields.
- PC_Write, IF_ID_Write and Bubble_EX are pure combinational functions of Stall, with no added delay.
- While rst_n=0: Stall=0, PC_Write=1, IF_ID_Write=1 and Bubble_EX=0, because combinational outputs are gated by rst_n.
- Stall_Prev <= Stall on every rising clk.
- Stall_Count increments by 1 on each rising clk where Stall=1. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- The hazard path is combinational, with zero-cycle latency from any input change to Stall and the derived enables.
- A single load-use produces exactly one stall cycle. On the next cycle the load has moved to MEM, and the EX stage holds the bubble with MemRead_EX=0, so Stall drops without any internal state.
- Asynchronous reset: on rst_n falling, Stall_Prev=0 and Stall_Count=0 immediately, independent of clk.
- After rst_n rises, registers update on the first rising clk.
- Reset asserted mid-stall: Stall is forced to 0 at once and the counter clears. The increment pending for that cycle is lost.
- If the counter is at saturation and Stall=1, the counter holds its value.
- Back-to-back loads each feeding ID produce consecutive stall cycles. Each counts once and Stall_Prev tracks each of them.

## Test plan
- All inputs 0, MemRead_EX=0 -> Stall=0, PC_Write=1, IF_ID_Write=1, Bubble_EX=0.
- MemRead_EX=1, Rs_ID=3, Rt_ID=5, Rt_EX=3 -> Stall=1, PC_Write=0, IF_ID_Write=0, Bubble_EX=1. After the next clk, Stall_Prev=1 and Stall_Count=1.
- MemRead_EX=1, Rs_ID=2, Rt_ID=5, Rt_EX=3 -> Stall=0. Stall_Count is unchanged after the clk.
- Cases that must give Stall=0 or a single stall:
  - MemRead_EX=1, Rs_ID=7, Rt_ID=3, Rt_EX=3 -> Stall=1, the Rt match.
  - Same with Rs_ID=Rt_ID=Rt_EX=0 -> Stall=0, the $zero exclusion.
  - MemRead_EX=0 with Rs_ID=Rt_EX=3 -> Stall=0.
- Reset behaviour:
  - Drive rst_n=0 asynchronously mid-cycle while Stall=1 -> Stall, Stall_Prev and Stall_Count go to 0 immediately.
  - Release rst_n and hold the hazard -> the count resumes from 1.
- Saturation: with CNT_W=2, hold the hazard for 5 clks -> Stall_Count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between ID and EX: combinational stall/enable generation
// plus a registered previous-stall flag and a saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [4:0]       Rt_EX,
    output logic             Stall,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             Bubble_EX,
    output logic             Stall_Prev,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rs_match;
    logic             rt_match;
    logic             dest_nonzero;
    logic             hazard;
    logic             stall_prev_reg;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] stall_count_next;

    // A load to $zero never creates a dependency, so it is excluded outright.
    assign rs_match     = (Rt_EX == Rs_ID);
    assign rt_match     = (Rt_EX == Rt_ID);
    assign dest_nonzero = (Rt_EX != 5'd0);
    assign hazard       = rst_n & MemRead_EX & dest_nonzero & (rs_match | rt_match);

    assign Stall       = hazard;
    assign PC_Write    = ~hazard;
    assign IF_ID_Write = ~hazard;
    assign Bubble_EX   = hazard;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (hazard && (stall_count_reg != CNT_MAX)) begin
            stall_count_next = stall_count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_prev_reg  <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            stall_prev_reg  <= hazard;
            stall_count_reg <= stall_count_next;
        end
    end

    assign Stall_Prev  = stall_prev_reg;
    assign Stall_Count = stall_count_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized and directed check of hazard_detection_unit against a rule-level model,
// run on a default-width instance and a 2-bit-counter instance sharing the same inputs.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read;
    logic [4:0] rs_id, rt_id, rt_ex;

    logic        stall_a, pcw_a, ifw_a, bub_a, prev_a;
    logic [15:0] cnt_a;
    logic        stall_b, pcw_b, ifw_b, bub_b, prev_b;
    logic [1:0]  cnt_b;

    int checks = 0;
    int passed = 0;

    int exp_prev  = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .MemRead_EX(mem_read),
        .Rs_ID(rs_id), .Rt_ID(rt_id), .Rt_EX(rt_ex),
        .Stall(stall_a), .PC_Write(pcw_a), .IF_ID_Write(ifw_a),
        .Bubble_EX(bub_a), .Stall_Prev(prev_a), .Stall_Count(cnt_a)
    );

    hazard_detection_unit #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .MemRead_EX(mem_read),
        .Rs_ID(rs_id), .Rt_ID(rt_id), .Rt_EX(rt_ex),
        .Stall(stall_b), .PC_Write(pcw_b), .IF_ID_Write(ifw_b),
        .Bubble_EX(bub_b), .Stall_Prev(prev_b), .Stall_Count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_stall(input int rst, input int mr, input int rs,
                                       input int rt, input int dst);
        if (rst == 0 || mr == 0 || dst == 0) return 0;
        return ((dst == rs) || (dst == rt)) ? 1 : 0;
    endfunction

    // One transaction: drive, check combinational outputs, clock, check registers.
    task automatic apply(input string tag, input int mr, input int rs, input int rt, input int dst);
        int s;
        mem_read = mr[0];
        rs_id    = rs[4:0];
        rt_id    = rt[4:0];
        rt_ex    = dst[4:0];
        #1;
        s = model_stall(int'(rst_n), mr, rs, rt, dst);
        check({tag, ".stall"},  32'(stall_a), 32'(s));
        check({tag, ".pcw"},    32'(pcw_a),   32'(1 - s));
        check({tag, ".ifw"},    32'(ifw_a),   32'(1 - s));
        check({tag, ".bubble"}, 32'(bub_a),   32'(s));
        check({tag, ".stall_b"},32'(stall_b), 32'(s));
        @(posedge clk);
        exp_prev = s;
        if (s == 1) begin
            exp_cnt_a = (exp_cnt_a == 65535) ? exp_cnt_a : exp_cnt_a + 1;
            exp_cnt_b = (exp_cnt_b == 3) ? exp_cnt_b : exp_cnt_b + 1;
        end
        #1;
        check({tag, ".prev_a"}, 32'(prev_a), 32'(exp_prev));
        check({tag, ".cnt_a"},  32'(cnt_a),  32'(exp_cnt_a));
        check({tag, ".prev_b"}, 32'(prev_b), 32'(exp_prev));
        check({tag, ".cnt_b"},  32'(cnt_b),  32'(exp_cnt_b));
        $display("txn %s mr=%0d rs=%0d rt=%0d rt_ex=%0d stall=%0d cnt=%0d cnt2=%0d",
                 tag, mr, rs, rt, dst, stall_a, cnt_a, cnt_b);
    endtask

    task automatic model_reset();
        exp_prev  = 0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};

        rst_n    = 1'b0;
        mem_read = 1'b1;
        rs_id    = 5'd3;
        rt_id    = 5'd3;
        rt_ex    = 5'd3;
        #12;
        check("rst.stall",  32'(stall_a), 32'd0);
        check("rst.pcw",    32'(pcw_a),   32'd1);
        check("rst.ifw",    32'(ifw_a),   32'd1);
        check("rst.bubble", 32'(bub_a),   32'd0);
        check("rst.prev",   32'(prev_a),  32'd0);
        check("rst.cnt",    32'(cnt_a),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        apply("idle",     0, 0, 0, 0);
        apply("rs_match", 1, 3, 5, 3);
        apply("no_match", 1, 2, 5, 3);
        apply("rt_match", 1, 7, 3, 3);
        apply("zero_reg", 1, 0, 0, 0);
        apply("no_load",  0, 3, 5, 3);
        apply("both",     1, 9, 9, 9);
        apply("b2b_1",    1, 4, 1, 4);
        apply("b2b_2",    1, 6, 6, 2);

        // Reset lands mid-cycle while the hazard is live.
        apply("pre_rst",  1, 3, 5, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.stall",  32'(stall_a), 32'd0);
        check("arst.pcw",    32'(pcw_a),   32'd1);
        check("arst.bubble", 32'(bub_a),   32'd0);
        check("arst.prev",   32'(prev_a),  32'd0);
        check("arst.cnt",    32'(cnt_a),   32'd0);
        check("arst.cnt_b",  32'(cnt_b),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("resume", 1, 3, 5, 3);
        check("resume.cnt_is_1", 32'(cnt_a), 32'd1);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            apply("sat", 1, 3, 5, 3);
            check("sat.cnt_b_seq", 32'(cnt_b), 32'(sat_exp[i]));
        end

        for (int i = 0; i < 200; i++) begin
            apply("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
